// File: rtl/msf_encoder.sv
// MSF transmit encoder: serialises one queued second symbol (marker or A/B
// bit pair) into the strobed on/off carrier sample stream.
module msf_encoder #(
    parameter int CLKS_PER_SAMPLE  = 4,
    parameter int SAMPLES_PER_SLOT = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       bits_valid_i,
    output logic       bits_ready_o,
    input  logic       bits_is_second_00_i,
    input  logic [1:0] bits_data_i,
    output logic       sample_valid_o,
    output logic       sample_data_o,
    output logic       second_start_o,
    output logic       underrun_o
);

    localparam int DW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam int SW = (SAMPLES_PER_SLOT > 1) ? $clog2(SAMPLES_PER_SLOT) : 1;

    typedef enum logic [1:0] {
        SYM_IDLE,
        SYM_MARKER,
        SYM_DATA
    } sym_e;

    logic [DW-1:0] div_q, div_d;
    logic [SW-1:0] samp_q, samp_d;
    logic [3:0]    slot_q, slot_d;
    sym_e          cur_q, cur_d;
    logic [1:0]    cur_ab_q, cur_ab_d;
    logic          pend_full_q, pend_full_d;
    logic          pend_mk_q, pend_mk_d;
    logic [1:0]    pend_ab_q, pend_ab_d;
    logic          valid_q, valid_d;
    logic          data_q, data_d;
    logic          ss_q, ss_d;
    logic          ur_q, ur_d;

    logic tick, samp_wrap, load, accept, slot_bit;

    always_comb begin
        tick      = (div_q == DW'(CLKS_PER_SAMPLE - 1));
        samp_wrap = (samp_q == SW'(SAMPLES_PER_SLOT - 1));
        load      = (div_q == '0) && (samp_q == '0) && (slot_q == '0);
        accept    = bits_valid_i && !pend_full_q;

        div_d  = tick ? '0 : div_q + DW'(1);
        samp_d = samp_q;
        slot_d = slot_q;
        if (tick) begin
            samp_d = samp_wrap ? '0 : samp_q + SW'(1);
            if (samp_wrap)
                slot_d = (slot_q == 4'd9) ? 4'd0 : slot_q + 4'd1;
        end

        // Load consumes pending first so a same-cycle handshake refills it
        pend_full_d = pend_full_q;
        pend_mk_d   = pend_mk_q;
        pend_ab_d   = pend_ab_q;
        cur_d       = cur_q;
        cur_ab_d    = cur_ab_q;
        if (load) begin
            pend_full_d = 1'b0;
            if (pend_full_q) begin
                cur_d    = pend_mk_q ? SYM_MARKER : SYM_DATA;
                cur_ab_d = pend_ab_q;
            end else begin
                cur_d    = SYM_IDLE;
                cur_ab_d = 2'b00;
            end
        end
        if (accept) begin
            pend_full_d = 1'b1;
            pend_mk_d   = bits_is_second_00_i;
            pend_ab_d   = bits_data_i;
        end

        slot_bit = 1'b1;
        case (cur_q)
            SYM_MARKER: slot_bit = (slot_q >= 4'd5);
            SYM_DATA: begin
                if (slot_q == 4'd0)
                    slot_bit = 1'b0;
                else if (slot_q == 4'd1)
                    slot_bit = ~cur_ab_q[1];
                else if (slot_q == 4'd2)
                    slot_bit = ~cur_ab_q[0];
            end
            default: slot_bit = 1'b1;
        endcase

        valid_d = tick;
        data_d  = tick ? slot_bit : data_q;
        ss_d    = load;
        ur_d    = load && !pend_full_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q       <= '0;
            samp_q      <= '0;
            slot_q      <= '0;
            cur_q       <= SYM_IDLE;
            cur_ab_q    <= 2'b00;
            pend_full_q <= 1'b0;
            pend_mk_q   <= 1'b0;
            pend_ab_q   <= 2'b00;
            valid_q     <= 1'b0;
            data_q      <= 1'b1;
            ss_q        <= 1'b0;
            ur_q        <= 1'b0;
        end else begin
            div_q       <= div_d;
            samp_q      <= samp_d;
            slot_q      <= slot_d;
            cur_q       <= cur_d;
            cur_ab_q    <= cur_ab_d;
            pend_full_q <= pend_full_d;
            pend_mk_q   <= pend_mk_d;
            pend_ab_q   <= pend_ab_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            ss_q        <= ss_d;
            ur_q        <= ur_d;
        end
    end

    assign bits_ready_o   = ~pend_full_q;
    assign sample_valid_o = valid_q;
    assign sample_data_o  = data_q;
    assign second_start_o = ss_q;
    assign underrun_o     = ur_q;

endmodule

// File: tb/tb_msf_encoder.sv
// Directed bench for msf_encoder with 4 clocks/sample, 2 samples/slot
// (20 samples = 80 cycles per second).
module tb_msf_encoder;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       bits_valid_i = 1'b0;
    logic       bits_ready_o;
    logic       bits_is_second_00_i = 1'b0;
    logic [1:0] bits_data_i = 2'b00;
    logic       sample_valid_o;
    logic       sample_data_o;
    logic       second_start_o;
    logic       underrun_o;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;

    // bit k = expected level of sample k within the second
    localparam logic [19:0] P_IDLE = 20'hFFFFF;
    localparam logic [19:0] P_MARK = 20'hFFC00;
    localparam logic [19:0] P_A1B0 = 20'hFFFF0;
    localparam logic [19:0] P_A0B1 = 20'hFFFCC;
    localparam logic [19:0] P_A1B1 = 20'hFFFC0;
    localparam logic [19:0] P_A0B0 = 20'hFFFFC;

    msf_encoder #(
        .CLKS_PER_SAMPLE (4),
        .SAMPLES_PER_SLOT(2)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .bits_valid_i       (bits_valid_i),
        .bits_ready_o       (bits_ready_o),
        .bits_is_second_00_i(bits_is_second_00_i),
        .bits_data_i        (bits_data_i),
        .sample_valid_o     (sample_valid_o),
        .sample_data_o      (sample_data_o),
        .second_start_o     (second_start_o),
        .underrun_o         (underrun_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic req);
        n_assert++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s @cycle %0d: observed %b expected %b",
                   tag, cyc, obs, req);
        end
    endtask

    task automatic step();
        int rel;
        @(posedge clk);
        #1;
        cyc++;
        rel = cyc - t0;
        chk("sample_valid", sample_valid_o, (rel > 0) && (rel % 4 == 0));
        chk("second_start", second_start_o, (rel % 80) == 1);
    endtask

    task automatic step_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        bits_valid_i = 1'b0;
        bits_is_second_00_i = 1'b0;
        bits_data_i = 2'b00;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        cyc = 0;
        t0 = 0;
    endtask

    task automatic offer(input logic mk, input logic [1:0] ab);
        bits_valid_i = 1'b1;
        bits_is_second_00_i = mk;
        bits_data_i = ab;
    endtask

    task automatic drop();
        bits_valid_i = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, sample_valid_o, 1'b0);
        chk({tag, "_data"}, sample_data_o, 1'b1);
        chk({tag, "_ss"}, second_start_o, 1'b0);
        chk({tag, "_ur"}, underrun_o, 1'b0);
        chk({tag, "_ready"}, bits_ready_o, 1'b1);
    endtask

    task automatic check_second(input int start, input logic [19:0] pat,
                                input string tag);
        for (int k = 0; k < 20; k++) begin
            step_to(start + 4 * (k + 1));
            chk(tag, sample_data_o, pat[k]);
        end
    endtask

    initial begin
        // 1: idle stream, underrun every second
        do_reset();
        check_reset_state("rst");
        check_second(0, P_IDLE, "idle0");
        step_to(81);
        chk("idle_ur81", underrun_o, 1'b1);
        check_second(80, P_IDLE, "idle1");
        step_to(161);
        chk("idle_ur161", underrun_o, 1'b1);

        // 2: marker
        do_reset();
        step_to(10);
        chk("mk_ready10", bits_ready_o, 1'b1);
        offer(1'b1, 2'b11);
        step_to(11);
        drop();
        chk("mk_ready11", bits_ready_o, 1'b0);
        step_to(81);
        chk("mk_ur81", underrun_o, 1'b0);
        chk("mk_ready81", bits_ready_o, 1'b1);
        check_second(80, P_MARK, "marker");
        step_to(161);
        chk("mk_ur161", underrun_o, 1'b1);

        // 3: two data symbols back to back
        do_reset();
        step_to(10);
        offer(1'b0, 2'b10);
        step_to(11);
        drop();
        step_to(81);
        chk("d_ur81", underrun_o, 1'b0);
        step_to(82);
        offer(1'b0, 2'b01);
        step_to(83);
        drop();
        check_second(80, P_A1B0, "data_a1b0");
        step_to(161);
        chk("d_ur161", underrun_o, 1'b0);
        check_second(160, P_A0B1, "data_a0b1");

        // 4: backpressure with two symbols
        do_reset();
        step_to(10);
        chk("bp_ready10", bits_ready_o, 1'b1);
        offer(1'b0, 2'b11);
        step_to(11);
        offer(1'b1, 2'b00);
        chk("bp_ready11", bits_ready_o, 1'b0);
        step_to(80);
        chk("bp_ready80", bits_ready_o, 1'b0);
        step_to(81);
        chk("bp_ready81", bits_ready_o, 1'b1);
        chk("bp_ur81", underrun_o, 1'b0);
        step_to(82);
        drop();
        chk("bp_ready82", bits_ready_o, 1'b0);
        check_second(80, P_A1B1, "bp_first");
        step_to(161);
        chk("bp_ur161", underrun_o, 1'b0);
        check_second(160, P_MARK, "bp_second");

        // 5: handshake on the load cycle itself
        do_reset();
        step_to(80);
        chk("sim_ready80", bits_ready_o, 1'b1);
        offer(1'b0, 2'b00);
        step_to(81);
        drop();
        chk("sim_ur81", underrun_o, 1'b1);
        chk("sim_ready81", bits_ready_o, 1'b0);
        check_second(80, P_IDLE, "sim_idle");
        step_to(161);
        chk("sim_ur161", underrun_o, 1'b0);
        check_second(160, P_A0B0, "sim_data");

        // 6: reset mid-second discards current and pending
        do_reset();
        step_to(10);
        offer(1'b0, 2'b10);
        step_to(11);
        drop();
        step_to(81);
        chk("mr_ur81", underrun_o, 1'b0);
        step_to(84);
        chk("mr_s0", sample_data_o, 1'b0);
        step_to(90);
        offer(1'b1, 2'b00);
        step_to(91);
        drop();
        chk("mr_ready91", bits_ready_o, 1'b0);
        step_to(96);
        chk("mr_s2", sample_data_o, 1'b0);
        step_to(110);
        chk("mr_ready110", bits_ready_o, 1'b0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        t0 = cyc;
        check_reset_state("mr_rst");
        step_to(112);
        chk("mr_ur112", underrun_o, 1'b1);
        check_second(111, P_IDLE, "mr_idle0");
        step_to(192);
        chk("mr_ur192", underrun_o, 1'b1);
        check_second(191, P_IDLE, "mr_idle1");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
